// File: rtl/shift_nibble_framer.sv
// shift_nibble_framer: hunts a sync pattern on a shift-register tap, then frames
// fixed-length runs of nibbles into a 2-entry valid/ready output FIFO.
module shift_nibble_framer #(
   parameter logic [3:0] SYNC_PAT      = 4'b1011,
   parameter int         FRAME_NIBBLES = 4
) (
   input  logic       clock,
   input  logic       clear,
   input  logic [3:0] par_in,
   output logic [3:0] nib_data,
   output logic       nib_valid,
   input  logic       nib_ready,
   output logic       locked,
   output logic       frame_done,
   output logic       overflow
);
   typedef enum logic {HUNT, LOCKED} state_t;
   localparam logic [3:0] LAST = 4'(FRAME_NIBBLES - 1);
   state_t     state;
   logic [1:0] bit_cnt;
   logic [3:0] nib_cnt;
   logic [3:0] head;
   logic [3:0] tail;
   logic [1:0] count;
   logic       push;
   logic       pop;
   assign push      = (state == LOCKED) && (bit_cnt == 2'd3);
   assign nib_valid = count != 2'd0;
   assign pop       = nib_valid && nib_ready;
   assign nib_data  = head;
   assign locked    = state == LOCKED;
   always_ff @(posedge clock) begin
      if (!clear) begin
         state      <= HUNT;
         bit_cnt    <= 2'd0;
         nib_cnt    <= 4'd0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state == HUNT) begin
            if (par_in == SYNC_PAT) begin
               state   <= LOCKED;
               bit_cnt <= 2'd0;
               nib_cnt <= 4'd0;
            end
         end else begin
            bit_cnt <= bit_cnt + 2'd1;
            if (push) begin
               // dropped nibbles still count: frame length is fixed in time
               nib_cnt <= nib_cnt + 4'd1;
               if (nib_cnt == LAST) begin
                  state      <= HUNT;
                  nib_cnt    <= 4'd0;
                  frame_done <= 1'b1;
               end
            end
         end
      end
   end
   always_ff @(posedge clock) begin
      if (!clear) begin
         head     <= 4'd0;
         tail     <= 4'd0;
         count    <= 2'd0;
         overflow <= 1'b0;
      end else if (push && pop) begin
         if (count == 2'd2) begin
            head <= tail;
            tail <= par_in;
         end else begin
            head <= par_in;
         end
      end else if (pop) begin
         head  <= tail;
         count <= count - 2'd1;
      end else if (push) begin
         if (count == 2'd0) head <= par_in;
         else if (count == 2'd1) tail <= par_in;
         else overflow <= 1'b1;
         if (count != 2'd2) count <= count + 2'd1;
      end
   end
endmodule

// File: doc/shift_nibble_framer.md
# shift_nibble_framer

Downstream consumer of the 4-bit serial-in/parallel-out shift register. Watches the register's parallel tap for a 4-bit sync pattern, then captures each subsequent fully-shifted nibble as one word of a fixed-length frame. Captured nibbles go into a 2-entry output FIFO with a valid/ready handshake. The register shifts one bit per clock, so framing is purely cycle-counted.

## Interface
Parameters:
- SYNC_PAT, 4'b1011: pattern on par_in that marks frame start.
- FRAME_NIBBLES, 4: nibbles captured per frame; legal range 1..15.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- clear  in  1  reset; synchronous, active-low.
- par_in  in  4  parallel tap of the upstream shift register; bit 0 is the newest bit, bit 3 the oldest; shifts every clock.
- nib_data  out  4  FIFO head nibble; par_in[3] is the first-received bit.
- nib_valid  out  1  FIFO non-empty.
- nib_ready  in  1  consumer accepts head when nib_valid && nib_ready at an edge.
- locked  out  1  high while in LOCKED state.
- frame_done  out  1  one-cycle pulse after the last nibble of a frame is pushed.
- overflow  out  1  sticky; set when a nibble is dropped because the FIFO is full.

## Operation
- Reset (clear low at an edge): state HUNT, bit_cnt=0, nib_cnt=0, FIFO empty.
  - Outputs after reset: nib_valid=0, nib_data=0, locked=0, frame_done=0, overflow=0.
  - Reset overrides everything, including mid-frame and a full FIFO; in-flight nibbles are discarded.
- State HUNT:
  - At each edge, if par_in==SYNC_PAT: go to LOCKED, bit_cnt=0, nib_cnt=0.
  - Otherwise stay in HUNT.
- State LOCKED: bit_cnt (2 bits) increments every edge.
  - At an edge with bit_cnt==3, push par_in into the FIFO, bit_cnt wraps to 0, and nib_cnt increments.
  - On the push where nib_cnt reaches FRAME_NIBBLES: go to HUNT and pulse frame_done.
  - The sync pattern is not re-checked while LOCKED; payload equal to SYNC_PAT is captured as data.
  - Return to HUNT happens on the same edge as the final push. par_in is compared against SYNC_PAT from the next edge onward.
- FIFO (depth 2, registered):
  - Pop when nib_valid && nib_ready.
  - Push when empty: entry becomes head.
  - Push and pop on the same edge: both take effect. This holds with the FIFO full, so occupancy stays 2 and no overflow occurs.
  - Push when full with no pop: new nibble dropped, overflow set to 1. overflow clears only on reset.
  - A dropped nibble still counts toward nib_cnt; frame length is fixed by time, not by acceptance.
  - Pop when empty: no effect.
- nib_data holds the head entry and must stay stable while nib_valid && !nib_ready.

## Timing
- Sync match sampled at edge E0. Payload nibbles are pushed at edges E4, E8, …, E(4·FRAME_NIBBLES).
- Push at edge En: nib_valid and nib_data reflect the nibble in the cycle after En (1-cycle latency).
- locked rises after E0 and falls after the final push edge.
- frame_done is high for exactly the cycle following the final push edge.
- Earliest next sync match: one edge after the final push.
- No combinational path from any input to any output.

## Test plan
- Reset and hunt: hold clear=0 for 2 cycles, then feed par_in values ≠ 4'b1011 for 10 cycles -> all outputs 0, locked stays 0.
- Sync and capture: sync at E0, then stream bits so par_in = 4'hA at E4, 4'h3 at E8, 4'hF at E12, 4'h0 at E16; nib_ready=1 throughout -> four nibbles A,3,F,0 each appear for one cycle after their push edge; frame_done pulses once after E16; locked falls after E16.
- Backpressure/overflow: same frame with nib_ready=0 -> A and 3 held in FIFO, F and 0 dropped, overflow=1 after E12 and remains 1. Raising nib_ready then yields A followed by 3, then nib_valid=0.
- Simultaneous push/pop when full: FIFO holds two entries, nib_ready=1 at a push edge -> head popped, new nibble enqueued, occupancy stays 2, overflow stays 0.
- Sync pattern in payload: second nibble equals 4'b1011 -> captured as data with no re-lock; frame still ends at E16.
- Reset mid-frame: drive clear=0 at E6 with FIFO holding 1 entry -> after that edge locked=0, nib_valid=0, frame_done=0, and the next frame starts cleanly on the next sync.
